mm_exp_sched: RTL and testbench

Sequencer that computes M^E mod N by time-sharing one Montgomery multiplier (MM) core instead of instantiating one core per step. It runs left-to-right binary square-and-multiply: conversion into the Montgomery domain, one square per exponent bit, one multiply per set bit, then conversion back out. It sits between the RSA top-level register interface and a single MM instance, and drives that instance's operands and handshake.

---
 rtl/rsa_pkg.sv | 23 ++
 rtl/exp_scan.sv | 44 ++++
 rtl/mm_exp_sched.sv | 147 ++++++++++++++
 tb/tb_mm_exp_sched.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and default sizes for the modular-exponentiation sequencer.
package rsa_pkg;

  localparam int W_DEF   = 32;
  localparam int EW_DEF  = 32;
  localparam int TMO_DEF = 4096;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD_X   = 3'd1,
    S_LD_ACC = 3'd2,
    S_SQR    = 3'd3,
    S_MUL    = 3'd4,
    S_OUT    = 3'd5
  } state_e;

  // Each MM step spends one cycle issuing, then waits for mm_done.
  typedef enum logic {
    PH_ISSUE = 1'b0,
    PH_WAIT  = 1'b1
  } phase_e;

endpackage

// File: rtl/exp_scan.sv
// Exponent scanner: holds e and the clamped length, walks the bit index
// from the MSB of the requested field down to bit 0.
module exp_scan
  import rsa_pkg::*;
#(
  parameter int EW = EW_DEF,
  parameter int IW = (EW > 1) ? $clog2(EW) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [EW-1:0] e,
  input  logic [5:0]    e_len,
  input  logic          step,
  output logic          cur_bit,
  output logic          last_bit,
  output logic          zero_len
);

  logic [EW-1:0] e_q;
  logic [IW-1:0] idx;
  logic [5:0]    len_c;

  // Requests longer than the exponent register are treated as full width.
  assign len_c = (e_len > 6'(EW)) ? 6'(EW) : e_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q      <= '0;
      idx      <= '0;
      zero_len <= 1'b0;
    end else if (load) begin
      e_q      <= e;
      zero_len <= (len_c == 6'd0);
      idx      <= (len_c == 6'd0) ? '0 : IW'(len_c - 6'd1);
    end else if (step && (idx != '0)) begin
      idx <= idx - IW'(1);
    end
  end

  assign cur_bit  = e_q[idx];
  assign last_bit = (idx == '0);

endmodule

// File: rtl/mm_exp_sched.sv
// Left-to-right square-and-multiply sequencer that time-shares a single
// Montgomery multiplier to compute m^e mod n.
module mm_exp_sched
  import rsa_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int EW  = EW_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  m,
  input  logic [EW-1:0] e,
  input  logic [5:0]    e_len,
  input  logic [W-1:0]  n,
  input  logic [W-1:0]  r2,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  result,
  output logic          mm_start,
  output logic [W-1:0]  mm_a,
  output logic [W-1:0]  mm_b,
  output logic [W-1:0]  mm_n,
  input  logic [W-1:0]  mm_z,
  input  logic          mm_done
);

  localparam int CW = $clog2(TMO + 1);

  state_e        state;
  phase_e        phase;
  logic [W-1:0]  m_q, n_q, r2_q, x_q, acc_q;
  logic [CW-1:0] tmo_cnt;
  logic          accept, wait_done, scan_step;
  logic          cur_bit, last_bit, zero_len;

  // The done/err cycle still counts as busy for the purpose of accepting work.
  assign accept    = (state == S_IDLE) && start && !done && !err;
  assign wait_done = (state != S_IDLE) && (phase == PH_WAIT) && mm_done;
  assign scan_step = wait_done &&
                     (((state == S_SQR) && !cur_bit && !last_bit) ||
                      ((state == S_MUL) && !last_bit));

  exp_scan #(.EW(EW)) u_scan (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .e        (e),
    .e_len    (e_len),
    .step     (scan_step),
    .cur_bit  (cur_bit),
    .last_bit (last_bit),
    .zero_len (zero_len)
  );

  // NOTE: sequential state uses non-blocking (<=) so every register in this
  // block samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are reset as well, because result and mm_n
      // are architecturally visible and must read zero after reset.
      state   <= S_IDLE;
      phase   <= PH_ISSUE;
      m_q     <= '0;
      n_q     <= '0;
      r2_q    <= '0;
      x_q     <= '0;
      acc_q   <= '0;
      tmo_cnt <= '0;
      result  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == S_IDLE) begin
        if (accept) begin
          m_q   <= m;
          n_q   <= n;
          r2_q  <= r2;
          state <= S_LD_X;
          phase <= PH_ISSUE;
        end
      end else if (phase == PH_ISSUE) begin
        phase   <= PH_WAIT;
        tmo_cnt <= '0;
      end else if (mm_done) begin
        phase <= PH_ISSUE;
        case (state)
          S_LD_X: begin
            x_q   <= mm_z;
            state <= S_LD_ACC;
          end
          S_LD_ACC: begin
            acc_q <= mm_z;
            state <= zero_len ? S_OUT : S_SQR;
          end
          S_SQR: begin
            acc_q <= mm_z;
            if (cur_bit)       state <= S_MUL;
            else if (last_bit) state <= S_OUT;
            else               state <= S_SQR;
          end
          S_MUL: begin
            acc_q <= mm_z;
            state <= last_bit ? S_OUT : S_SQR;
          end
          S_OUT: begin
            result <= mm_z;
            done   <= 1'b1;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end else if (tmo_cnt == CW'(TMO - 1)) begin
        // Core never answered: abandon the operation, keep the old result.
        err   <= 1'b1;
        state <= S_IDLE;
        phase <= PH_ISSUE;
      end else begin
        tmo_cnt <= tmo_cnt + CW'(1);
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    mm_a = '0;
    mm_b = '0;
    case (state)
      S_LD_X:   begin mm_a = m_q;   mm_b = r2_q;  end
      S_LD_ACC: begin mm_a = W'(1); mm_b = r2_q;  end
      S_SQR:    begin mm_a = acc_q; mm_b = acc_q; end
      S_MUL:    begin mm_a = acc_q; mm_b = x_q;   end
      S_OUT:    begin mm_a = acc_q; mm_b = W'(1); end
      default:  begin mm_a = '0;    mm_b = '0;    end
    endcase
  end

  assign busy     = (state != S_IDLE);
  assign mm_start = (state != S_IDLE) && (phase == PH_ISSUE);
  assign mm_n     = n_q;

endmodule

// File: tb/tb_mm_exp_sched.sv
// Randomized bench for mm_exp_sched with a behavioural Montgomery core of
// random latency and a plain-arithmetic modular-exponentiation reference.
module tb_mm_exp_sched;

  localparam int W   = 32;
  localparam int EW  = 32;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  m, n, r2;
  logic [EW-1:0] e;
  logic [5:0]    e_len;
  logic          busy, done, err;
  logic [W-1:0]  result;
  logic          mm_start;
  logic [W-1:0]  mm_a, mm_b, mm_n, mm_z;
  logic          mm_done, mdl_done, stray_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_start = 0;
  int last_start_cyc = 0;
  bit hang = 1'b0;

  assign mm_done = mdl_done | stray_done;

  mm_exp_sched #(.W(W), .EW(EW), .TMO(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .m        (m),
    .e        (e),
    .e_len    (e_len),
    .n        (n),
    .r2       (r2),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result),
    .mm_start (mm_start),
    .mm_a     (mm_a),
    .mm_b     (mm_b),
    .mm_n     (mm_n),
    .mm_z     (mm_z),
    .mm_done  (mm_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // a*b*2^-32 mod nn, by halving modulo an odd nn 32 times.
  function automatic longint unsigned mont(input longint unsigned a,
                                           input longint unsigned b,
                                           input longint unsigned nn);
    longint unsigned t;
    t = (a * b) % nn;
    for (int i = 0; i < 32; i++) begin
      if (t[0]) t = t + nn;
      t = t >> 1;
    end
    return t;
  endfunction

  function automatic int eff_len(input int lv);
    return (lv > EW) ? EW : lv;
  endfunction

  function automatic longint unsigned modpow(input longint unsigned mv,
                                             input logic [EW-1:0] ev,
                                             input int lv,
                                             input longint unsigned nn);
    longint unsigned r, b;
    r = 1 % nn;
    b = mv % nn;
    for (int i = eff_len(lv) - 1; i >= 0; i--) begin
      r = (r * r) % nn;
      if (ev[i]) r = (r * b) % nn;
    end
    return r;
  endfunction

  function automatic int steps_of(input logic [EW-1:0] ev, input int lv);
    int s;
    s = 3 + eff_len(lv);
    for (int i = 0; i < eff_len(lv); i++) s += int'(ev[i]);
    return s;
  endfunction

  function automatic logic [W-1:0] r2_of(input longint unsigned nn);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < 64; i++) r = (r << 1) % nn;
    return W'(r);
  endfunction

  // Behavioural MM core: captures operands on mm_start, answers after
  // 1..20 cycles, and insists the operands stay put while it works.
  initial begin
    logic [W-1:0] ca, cb, cn;
    int lat;
    bit aborted;
    mdl_done = 1'b0;
    mm_z     = '0;
    forever begin
      @(negedge clk);
      mdl_done = 1'b0;
      if (mm_start && !hang) begin
        ca = mm_a; cb = mm_b; cn = mm_n;
        lat = $urandom_range(1, 20);
        aborted = 1'b0;
        for (int k = 0; k < lat; k++) begin
          @(negedge clk);
          if (!busy) begin
            aborted = 1'b1;
            break;
          end
          check("mm_ops_stable", {mm_a, mm_b}, {ca, cb});
        end
        if (!aborted) begin
          mm_z     = W'(mont(ca, cb, cn));
          mdl_done = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare process for the invariants that hold on every cycle.
  always @(negedge clk) begin
    if (mm_start) begin
      n_start++;
      last_start_cyc = cyc;
      check("start_implies_busy", busy, 1);
    end
    if (!busy) check("idle_ops_zero", {mm_a, mm_b}, 0);
    if (done || err) check("busy_low_at_end", busy, 0);
  end

  task automatic scramble();
    m = $urandom; e = $urandom; e_len = 6'($urandom); n = $urandom; r2 = $urandom;
  endtask

  // Called just after a negedge; leaves start asserted for one cycle.
  task automatic launch(input logic [W-1:0] mv, input logic [EW-1:0] ev,
                        input logic [5:0] lv, input logic [W-1:0] nv);
    m = mv; e = ev; e_len = lv; n = nv; r2 = r2_of(nv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
  endtask

  // Waits (bounded) for done/err and checks result and MM step count.
  task automatic finish_op(input string name, input logic [W-1:0] exp_res,
                           input int exp_steps);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      if (done || err) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      check({name, "_no_done"}, 0, 1);
    end else begin
      check({name, "_done"}, {done, err}, 2'b10);
      check({name, "_result"}, result, exp_res);
      check({name, "_steps"}, n_start, exp_steps);
    end
  endtask

  task automatic random_op(input string name, input bit long_len);
    logic [W-1:0]  nv, mv;
    logic [EW-1:0] ev;
    logic [5:0]    lv;
    nv = W'($urandom) | W'(1);
    if (nv < 3) nv = 3;
    mv = W'($urandom) % nv;
    ev = EW'($urandom);
    lv = long_len ? 6'($urandom_range(33, 63)) : 6'($urandom_range(0, 32));
    n_start = 0;
    launch(mv, ev, lv, nv);
    finish_op(name, W'(modpow(mv, ev, int'(lv), nv)), steps_of(ev, int'(lv)));
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] held;
    bit seen;
    int err_cyc;
    rst = 1'b1; start = 1'b0; stray_done = 1'b0;
    m = '0; e = '0; e_len = '0; n = '0; r2 = '0;
    repeat (3) @(negedge clk);
    check("reset_flags", {busy, done, err, mm_start}, 0);
    check("reset_result", result, 0);
    check("reset_ops", {mm_a, mm_b, mm_n}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 4^3 mod 13 = 12, 7 MM steps; first mm_start one cycle after start.
    n_start = 0;
    launch(32'd4, 32'd3, 6'd2, 32'd13);
    check("start_to_mm_start", mm_start, 1);
    finish_op("a", 32'd12, 7);
    @(negedge clk);
    check("result_held", result, 32'd12);

    // Stray mm_done while idle must do nothing.
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    @(negedge clk);
    check("stray_done_ignored", {busy, mm_start, done}, 0);
    check("stray_done_result", result, 32'd12);

    // 7^10 mod 11 = 1, 9 steps.
    n_start = 0;
    launch(32'd7, 32'd10, 6'd4, 32'd11);
    finish_op("b", 32'd1, 9);
    @(negedge clk);

    // e_len = 0 gives 1 after 3 steps; a start held across the done cycle
    // is only taken on the following cycle.
    n_start = 0;
    launch(32'd9, 32'hFFFF_FFFF, 6'd0, 32'd13);
    finish_op("c", 32'd1, 3);
    m = 32'd2; e = 32'd5; e_len = 6'd3; n = 32'd13; r2 = r2_of(13);
    start = 1'b1;
    @(negedge clk);
    check("start_in_done_cycle_ignored", mm_start, 0);
    n_start = 0;
    @(negedge clk);
    start = 1'b0;
    scramble();
    check("restart_next_cycle", mm_start, 1);
    finish_op("c2", 32'd6, 8);
    @(negedge clk);

    // A second start while busy is ignored: 5^11 mod 23 = 22.
    n_start = 0;
    launch(32'd5, 32'hB, 6'd4, 32'd23);
    repeat (10) @(negedge clk);
    m = 32'd9; e = 32'hFFFF; e_len = 6'd16; n = 32'd101; r2 = r2_of(101);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    finish_op("busy_start", 32'd22, 10);
    @(negedge clk);

    // Reset during the first SQR wait, then a clean rerun.
    n_start = 0;
    launch(32'd12345, 32'hDEAD_BEEF, 6'd20, 32'd1_000_003);
    seen = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (n_start >= 3) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reached_sqr", seen, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_flags", {busy, done, err, mm_start}, 0);
    check("midrst_result", result, 0);
    check("midrst_ops", {mm_a, mm_b, mm_n}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_start = 0;
    launch(32'd2, 32'd5, 6'd3, 32'd13);
    finish_op("after_rst", 32'd6, 8);
    @(negedge clk);

    // Randomized operations, including clamped lengths.
    for (int i = 0; i < 12; i++) random_op("rnd", 1'b0);
    random_op("clamp", 1'b1);
    random_op("clamp", 1'b1);

    // Core never answers: err 64 cycles into the wait, result untouched.
    held = result;
    hang = 1'b1;
    n_start = 0;
    launch(32'd3, 32'd7, 6'd3, 32'd97);
    seen = 1'b0;
    err_cyc = 0;
    for (int k = 0; k < 300; k++) begin
      if (err || done) begin
        seen = 1'b1;
        err_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    check("tmo_seen", {seen, err, done}, 3'b110);
    check("tmo_latency", err_cyc - last_start_cyc, TMO + 1);
    check("tmo_result_kept", result, held);
    check("tmo_steps", n_start, 1);
    hang = 1'b0;
    @(negedge clk);
    check("tmo_idle", {busy, err}, 0);
    random_op("post_tmo", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute backstop so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got cycle %0d want finish", cyc);
    $fatal(1, "bench did not finish");
  end

endmodule
